// File: rtl/ps2_rx_frame_pkg.sv
// Shared definitions for the PS/2 receive frame decoder: FSM state
// encoding, frame geometry, default parameter values and the parity helper.
package ps2_rx_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 3;

    localparam logic [15:0] TIMEOUT_DEFAULT    = 16'd10000;
    localparam int unsigned FILTER_LEN_DEFAULT = 8;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer for one raw PS/2 line followed by an optional
// glitch filter. FILTER_LEN == 0 bypasses the filter (used for ps2_data,
// which is only sampled on a clean ps2_clk edge). With FILTER_LEN > 0 the
// output level changes only after FILTER_LEN consecutive samples that
// differ from it. All flops reset to 1 (idle line).
module ps2_line_filter
    import ps2_rx_frame_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level
);

    logic sync1_r;
    logic sync2_r;

    // Metastability guard: bring the asynchronous line into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= line;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign level = sync2_r;
        end else begin : g_filter
            localparam int unsigned CW = $clog2(FILTER_LEN + 1);

            logic [CW-1:0] cnt_r;
            logic          level_r;

            // Count consecutive disagreeing samples; flip the level once enough accumulate.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_r   <= '0;
                    level_r <= 1'b1;
                end else if (sync2_r == level_r) begin
                    cnt_r   <= '0;
                    level_r <= level_r;
                end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
                    cnt_r   <= '0;
                    level_r <= sync2_r;
                end else begin
                    cnt_r   <= cnt_r + CW'(1);
                    level_r <= level_r;
                end
            end

            assign level = level_r;
        end
    endgenerate

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver. Synchronizes and filters the PS/2
// lines, strobes on each falling edge of the filtered clock and decodes
// the 11-bit frame (start, 8 data LSB first, odd parity, stop).
// Optional build macro PS2_RX_PARITY_CHK_EN: when defined, a parity
// mismatch is reported on rx_err; otherwise the parity bit is ignored.
module ps2_rx_frame
    import ps2_rx_frame_pkg::*;
#(
    parameter logic [15:0] TIMEOUT    = TIMEOUT_DEFAULT,
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    ps2_state_t  state_r;
    ps2_state_t  state_nxt_s;
    logic        clk_f_s;
    logic        data_f_s;
    logic        clk_prev_r;
    logic        strobe_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_cnt_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic [15:0] wdog_r;
    logic [15:0] wdog_nxt_s;
    logic        timeout_s;
    logic        parity_ok_s;
    logic        load_s;
    logic        err_s;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        rx_err_r;
    logic        busy_r;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_clk),
        .level (clk_f_s)
    );

    ps2_line_filter #(.FILTER_LEN(0)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .line  (ps2_data),
        .level (data_f_s)
    );

    // A disabled receiver ignores edges entirely; the edge detector keeps
    // tracking the line so re-enabling cannot produce a stale strobe.
    assign strobe_s = rx_en & clk_prev_r & ~clk_f_s;

    // The watchdog fires on the cycle that completes TIMEOUT strobe-less cycles.
    assign timeout_s = (state_r != ST_IDLE) && !strobe_s && (wdog_r >= (TIMEOUT - 16'd1));

`ifdef PS2_RX_PARITY_CHK_EN
    logic parity_r;

    // Capture the parity bit so it can be checked when the stop bit arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if ((state_r == ST_PARITY) && strobe_s) begin
            parity_r <= data_f_s;
        end else begin
            parity_r <= parity_r;
        end
    end

    assign parity_ok_s = odd_parity_ok(shift_r, parity_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Next-state, shift register and result decode for the frame FSM.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        load_s        = 1'b0;
        err_s         = 1'b0;
        if (!rx_en) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 3'd0;
        end else if (timeout_s) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 3'd0;
            err_s         = 1'b1;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!data_f_s) begin
                        state_nxt_s   = ST_DATA;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_nxt_s = {data_f_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                        state_nxt_s   = ST_PARITY;
                        bit_cnt_nxt_s = 3'd0;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    state_nxt_s = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt_s = ST_IDLE;
                    if (data_f_s && parity_ok_s) begin
                        load_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    bit_cnt_nxt_s = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Watchdog: cleared by activity or idleness, otherwise counts and saturates.
    always_comb begin
        wdog_nxt_s = wdog_r;
        if ((state_r == ST_IDLE) || strobe_s) begin
            wdog_nxt_s = 16'd0;
        end else if (wdog_r == TIMEOUT) begin
            wdog_nxt_s = wdog_r;
        end else begin
            wdog_nxt_s = wdog_r + 16'd1;
        end
    end

    // FSM, datapath, watchdog and edge-detector state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            wdog_r     <= 16'd0;
            clk_prev_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            wdog_r     <= wdog_nxt_s;
            clk_prev_r <= clk_f_s;
        end
    end

    // Registered outputs: result byte, one-cycle pulses and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (load_s) begin
                rx_data_r <= shift_r;
            end else begin
                rx_data_r <= rx_data_r;
            end
            rx_valid_r <= load_s;
            rx_err_r   <= err_s & ~load_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;
    assign busy     = busy_r;

endmodule
